nv_ram_rwsp_param: RTL and testbench

Parametrised two-port RAM: one registered-read port and one write port, a single clock. It is the generalised successor to the fixed-size rws macros and adds:
- configurable width and depth (depth need not be a power of two)
- byte write mask
- read-during-write bypass
- optional output register stage
- a post-reset clear sequencer
- a sleep/wake power-down state machine driven by pwrbus_ram_pd

Used wherever datapath buffers need a non-standard geometry.

---
 rtl/nv_ram_rwsp_param.sv | 218 +++++++++++++++++++++
 tb/tb_nv_ram_rwsp_param.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_rwsp_param.sv
// ---------------------------------------------------------------------------
// nv_ram_rwsp_param
// Parametrised RAM with one registered-read port and one byte-masked write
// port on a single clock. It provides same-address read-during-write bypass,
// an optional second output flop, a post-reset zero-fill sequencer and a
// sleep/wake power-down controller.
//
// Parameters
//   DEPTH      number of entries (2..4096, need not be a power of two)
//   AW         address width, 2**AW >= DEPTH
//   DW         data width, multiple of 8
//   OUT_REG    0: read latency 1, 1: read latency 2
//   CLR_ON_RST 1: zero every entry after reset before accepting traffic
//   WAKE_CYC   cycles spent in WAKE before returning to ACTIVE (1..255)
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   ra, re           read address / read enable
//   dout, dout_vld   read data, one-cycle pulse marking new dout
//   wa, we           write address / write enable
//   wmask            byte write enables, bit i covers di[8i+7:8i]
//   di               write data
//   pwrbus_ram_pd    power control, bit 0 = sleep request, rest ignored
//   ready            high while reads and writes are accepted
// ---------------------------------------------------------------------------
module nv_ram_rwsp_param #(
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned AW         = 7,
  parameter int unsigned DW         = 64,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned CLR_ON_RST = 1,
  parameter int unsigned WAKE_CYC   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     ra,
  input  logic              re,
  output logic [DW-1:0]     dout,
  output logic              dout_vld,
  input  logic [AW-1:0]     wa,
  input  logic              we,
  input  logic [DW/8-1:0]   wmask,
  input  logic [DW-1:0]     di,
  input  logic [31:0]       pwrbus_ram_pd,
  output logic              ready
);

  localparam int unsigned NB  = DW / 8;
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WCW = 8;

  // Entry count widened by one bit so DEPTH == 2**AW still fits.
  localparam logic [AW:0]  DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [IW-1:0] CLR_LAST = IW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_SLEEP  = 2'd2,
    ST_WAKE   = 2'd3
  } state_t;

  localparam state_t RST_ST = (CLR_ON_RST != 0) ? ST_CLEAR : ST_ACTIVE;

  state_t             r_state;
  logic [IW-1:0]      r_clr_cnt;
  logic [WCW-1:0]     r_wake_cnt;

  logic [DW-1:0]      r_mem [DEPTH];

  logic               r_s1_vld;
  logic [DW-1:0]      r_s1_data;

  logic               w_pd;
  logic               w_unused_pd;
  logic               w_ra_ok;
  logic               w_wa_ok;
  logic               w_rd_acc;
  logic               w_wr_acc;
  logic               w_clr_wr;
  logic [IW-1:0]      w_ra_idx;
  logic [IW-1:0]      w_wa_idx;
  logic [DW-1:0]      w_rd_data;

  // Only bit 0 of the power bus carries meaning.
  assign w_pd        = pwrbus_ram_pd[0];
  assign w_unused_pd = ^pwrbus_ram_pd[31:1];

  assign ready    = (r_state == ST_ACTIVE);

  assign w_ra_ok  = ({1'b0, ra} < DEPTH_W);
  assign w_wa_ok  = ({1'b0, wa} < DEPTH_W);
  assign w_ra_idx = IW'(ra);
  assign w_wa_idx = IW'(wa);

  // Out-of-range reads are still accepted (they return zero); out-of-range
  // writes are dropped.
  assign w_rd_acc = re & ready;
  assign w_wr_acc = we & ready & w_wa_ok;

  // Held off while rst is high so reset alone never touches the array.
  assign w_clr_wr = (r_state == ST_CLEAR) & ~rst;

  // Power / clear state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RST_ST;
      r_clr_cnt  <= '0;
      r_wake_cnt <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          // Sleep request is only honoured once the last entry is zeroed.
          if (r_clr_cnt == CLR_LAST) begin
            r_clr_cnt <= '0;
            r_state   <= w_pd ? ST_SLEEP : ST_ACTIVE;
          end else begin
            r_clr_cnt <= r_clr_cnt + IW'(1);
          end
        end
        ST_ACTIVE: begin
          if (w_pd) begin
            r_state <= ST_SLEEP;
          end
        end
        ST_SLEEP: begin
          if (!w_pd) begin
            r_state    <= ST_WAKE;
            r_wake_cnt <= WCW'(WAKE_CYC);
          end
        end
        ST_WAKE: begin
          // A renewed sleep request aborts the wake-up immediately.
          if (w_pd) begin
            r_state    <= ST_SLEEP;
            r_wake_cnt <= '0;
          end else if (r_wake_cnt <= WCW'(1)) begin
            r_state    <= ST_ACTIVE;
            r_wake_cnt <= '0;
          end else begin
            r_wake_cnt <= r_wake_cnt - WCW'(1);
          end
        end
        default: begin
          r_state <= RST_ST;
        end
      endcase
    end
  end

  // Storage array: zero-fill during CLEAR, byte-masked writes otherwise.
  always_ff @(posedge clk) begin
    if (w_clr_wr) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (wmask[b]) begin
          r_mem[w_wa_idx][8*b +: 8] <= di[8*b +: 8];
        end
      end
    end
  end

  // Read mux with same-cycle write bypass merged byte by byte.
  always_comb begin
    w_rd_data = '0;
    if (w_ra_ok) begin
      w_rd_data = r_mem[w_ra_idx];
      if (w_wr_acc && (wa == ra)) begin
        for (int b = 0; b < NB; b++) begin
          if (wmask[b]) begin
            w_rd_data[8*b +: 8] = di[8*b +: 8];
          end
        end
      end
    end
  end

  // First read stage; data holds until the next accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_data <= w_rd_data;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic          r_s2_vld;
      logic [DW-1:0] r_s2_data;

      // Extra output flop; loads only when stage 1 carries a new result.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_s2_vld  <= 1'b0;
          r_s2_data <= '0;
        end else begin
          r_s2_vld <= r_s1_vld;
          if (r_s1_vld) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign dout     = r_s2_data;
      assign dout_vld = r_s2_vld;
    end else begin : g_no_out_reg
      assign dout     = r_s1_data;
      assign dout_vld = r_s1_vld;
    end
  endgenerate

endmodule

// File: tb/tb_nv_ram_rwsp_param.sv
// ---------------------------------------------------------------------------
// Bench for nv_ram_rwsp_param. Two instances share every input: one with
// read latency 1 (OUT_REG=0), one with latency 2 (OUT_REG=1). A behavioural
// model tracks array contents, power mode and pending read results; a
// negedge process compares both instances to it every cycle. Directed
// sections pin the model with hand-computed literal expectations, then a
// randomized phase runs against the model alone.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nv_ram_rwsp_param;

  localparam int DEPTH    = 100;
  localparam int AW       = 7;
  localparam int DW       = 64;
  localparam int NB       = 8;
  localparam int WAKE_CYC = 4;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic [AW-1:0] ra    = '0;
  logic [AW-1:0] wa    = '0;
  logic          re    = 1'b0;
  logic          we    = 1'b0;
  logic [NB-1:0] wmask = '0;
  logic [DW-1:0] di    = '0;
  logic [31:0]   pd    = '0;

  logic [DW-1:0] dout_a, dout_b;
  logic          vld_a, vld_b, ready_a, ready_b;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  nv_ram_rwsp_param #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .OUT_REG(0), .CLR_ON_RST(1), .WAKE_CYC(WAKE_CYC)
  ) u_dut_a (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_a), .dout_vld(vld_a),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pd), .ready(ready_a)
  );

  nv_ram_rwsp_param #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .OUT_REG(1), .CLR_ON_RST(1), .WAKE_CYC(WAKE_CYC)
  ) u_dut_b (
    .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout_b), .dout_vld(vld_b),
    .wa(wa), .we(we), .wmask(wmask), .di(di), .pwrbus_ram_pd(pd), .ready(ready_b)
  );

  // ---------------- behavioural model ----------------
  typedef enum int {M_CLEAR, M_ACTIVE, M_SLEEP, M_WAKE} mmode_t;
  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } pend_t;

  logic [DW-1:0] m_mem [DEPTH];
  mmode_t        m_mode = M_CLEAR;
  int            m_clr_left  = DEPTH;
  int            m_wake_left = 0;
  int            m_cyc       = 0;
  pend_t         q_a[$];
  pend_t         q_b[$];
  logic [DW-1:0] m_dout_a = '0;
  logic [DW-1:0] m_dout_b = '0;
  bit            m_vld_a  = 1'b0;
  bit            m_vld_b  = 1'b0;
  bit            m_ready  = 1'b0;
  bit            m_rdy, m_wr_ok;
  logic [DW-1:0] m_rv;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [NB-1:0] m);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < NB; b++) begin
      if (m[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode      = M_CLEAR;
      m_clr_left  = DEPTH;
      m_wake_left = 0;
      q_a.delete();
      q_b.delete();
      m_dout_a    = '0;
      m_dout_b    = '0;
      m_vld_a     = 1'b0;
      m_vld_b     = 1'b0;
      m_ready     = 1'b0;
    end else begin
      m_cyc   = m_cyc + 1;
      m_rdy   = (m_mode == M_ACTIVE);
      m_wr_ok = we && m_rdy && (int'(wa) < DEPTH);
      m_vld_a = 1'b0;
      m_vld_b = 1'b0;
      if (re && m_rdy) begin
        m_rv = (int'(ra) < DEPTH) ? m_mem[ra] : '0;
        if ((int'(ra) < DEPTH) && m_wr_ok && (wa == ra)) m_rv = merge(m_rv, di, wmask);
        q_a.push_back('{d: m_rv, due: m_cyc});
        q_b.push_back('{d: m_rv, due: m_cyc + 1});
      end
      if (q_a.size() > 0 && q_a[0].due == m_cyc) begin
        m_dout_a = q_a[0].d;
        m_vld_a  = 1'b1;
        void'(q_a.pop_front());
      end
      if (q_b.size() > 0 && q_b[0].due == m_cyc) begin
        m_dout_b = q_b[0].d;
        m_vld_b  = 1'b1;
        void'(q_b.pop_front());
      end
      if (m_mode == M_CLEAR) m_mem[7'(DEPTH - m_clr_left)] = '0;
      else if (m_wr_ok) m_mem[wa] = merge(m_mem[wa], di, wmask);
      case (m_mode)
        M_CLEAR: begin
          m_clr_left = m_clr_left - 1;
          if (m_clr_left == 0) m_mode = pd[0] ? M_SLEEP : M_ACTIVE;
        end
        M_ACTIVE: if (pd[0]) m_mode = M_SLEEP;
        M_SLEEP: if (!pd[0]) begin
          m_mode      = M_WAKE;
          m_wake_left = WAKE_CYC;
        end
        default: begin
          if (pd[0]) m_mode = M_SLEEP;
          else begin
            m_wake_left = m_wake_left - 1;
            if (m_wake_left == 0) m_mode = M_ACTIVE;
          end
        end
      endcase
      m_ready = (m_mode == M_ACTIVE);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready_a", 64'(ready_a), 64'(m_ready));
      chk("ready_b", 64'(ready_b), 64'(m_ready));
      chk("vld_a",   64'(vld_a),   64'(m_vld_a));
      chk("vld_b",   64'(vld_b),   64'(m_vld_b));
      chk("dout_a",  dout_a,       m_dout_a);
      chk("dout_b",  dout_b,       m_dout_b);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    re = 1'b0;
    we = 1'b0;
  endtask

  task automatic wait_ready(input string nm, input int exp_n);
    int n;
    n = 0;
    while (!ready_a && n < 400) begin
      n = n + 1;
      tick();
    end
    chk(nm, 64'(n), 64'(exp_n));
  endtask

  function automatic logic [DW-1:0] sval(input int i);
    return {32'hC0DE0000 + 32'(i), 32'h0BADF00D ^ 32'(i * 7)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Clear sequence: ready low exactly DEPTH cycles, entries read zero.
    wait_ready("clear_len", DEPTH);
    ra = 7'd0;  re = 1'b1; tick(); chk("clr_vld0", 64'(vld_a), 64'd1); chk("clr_rd0", dout_a, 64'd0);
    ra = 7'd57;            tick(); chk("clr_vld57", 64'(vld_a), 64'd1); chk("clr_rd57", dout_a, 64'd0);
    ra = 7'd99;            tick(); chk("clr_vld99", 64'(vld_a), 64'd1); chk("clr_rd99", dout_a, 64'd0);
    idle(); tick();

    // Byte mask.
    we = 1'b1; wa = 7'd5; di = 64'h1122334455667788; wmask = 8'hFF; tick();
    di = 64'hAAAAAAAAAAAAAAAA; wmask = 8'h0F; tick();
    we = 1'b0; re = 1'b1; ra = 7'd5; tick();
    re = 1'b0;
    chk("mask_a", dout_a, 64'h11223344AAAAAAAA);
    tick();
    chk("mask_b", dout_b, 64'h11223344AAAAAAAA);
    chk("mask_vld_b", 64'(vld_b), 64'd1);

    // Read-during-write to the same address.
    we = 1'b1; re = 1'b1; wa = 7'd9; ra = 7'd9; di = 64'hDEADBEEF00000001; wmask = 8'hF0; tick();
    idle();
    chk("rdw_a", dout_a, 64'hDEADBEEF00000000);
    chk("rdw_vld_b_early", 64'(vld_b), 64'd0);
    tick();
    chk("rdw_b", dout_b, 64'hDEADBEEF00000000);
    chk("rdw_vld_b", 64'(vld_b), 64'd1);

    // Sleep / wake.
    pd = 32'h1; tick();
    chk("sleep_ready", 64'(ready_a), 64'd0);
    we = 1'b1; wa = 7'd5; di = '1; wmask = 8'hFF; re = 1'b1; ra = 7'd5; tick();
    idle();
    chk("sleep_no_rd", 64'(vld_a), 64'd0);
    pd = 32'hFFFF_FFFE; tick();
    wait_ready("wake_len", WAKE_CYC);
    re = 1'b1; ra = 7'd5; tick(); idle();
    chk("wake_keep", dout_a, 64'h11223344AAAAAAAA);
    pd = 32'h1; tick();
    pd = 32'h0; tick(); tick(); tick();
    pd = 32'h1; tick();
    chk("wake_abort", 64'(ready_a), 64'd0);
    tick();
    chk("wake_abort2", 64'(ready_b), 64'd0);
    pd = 32'h0; tick();
    wait_ready("wake_len2", WAKE_CYC);

    // Out-of-range write dropped, out-of-range read returns zero.
    we = 1'b1; wa = 7'd120; di = 64'h5555555555555555; wmask = 8'hFF; tick();
    we = 1'b0; re = 1'b1; ra = 7'd5; tick();
    ra = 7'd110; tick();
    chk("oor_rd", dout_a, 64'd0);
    chk("oor_vld", 64'(vld_a), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      ra = 7'(i); tick();
    end
    idle(); tick();

    // Reset with a read in flight in the latency-2 instance.
    re = 1'b1; ra = 7'd5; tick();
    tick();
    idle();
    #1 rst = 1'b1;
    #1 chk("rst_vld_b", 64'(vld_b), 64'd0);
    chk("rst_dout_b", dout_b, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_vld_b", 64'(vld_b), 64'd0);
    end
    rst = 1'b0;
    wait_ready("clear_len2", DEPTH);

    // Streaming reads at both latencies.
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; wa = 7'(i); di = sval(i); wmask = 8'hFF; tick();
    end
    we = 1'b0;
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      re = 1'b1; ra = 7'(i); tick();
      chk("strm_a", dout_a, sval(i));
      chk("strm_vld_a", 64'(vld_a), 64'd1);
      if (i > 0) chk("strm_b", dout_b, sval(i - 1));
      nb = nb + int'(vld_b);
    end
    idle(); tick();
    nb = nb + int'(vld_b);
    chk("strm_b_last", dout_b, sval(15));
    chk("strm_b_pulses", 64'(nb), 64'd16);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      re    = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      ra    = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, DEPTH - 1));
      wa    = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 7) == 0) wa = ra;
      wmask = 8'($urandom_range(0, 255));
      di    = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 63) == 0) pd[0] = ~pd[0];
      if (n == 1500) begin
        #1 rst = 1'b1;
      end
      if (n == 1502) rst = 1'b0;
      tick();
    end
    idle();
    pd = 32'h0;
    repeat (120) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
